// File: rtl/sd_spi_responder.sv
// SPI-mode SDHC card emulator: decodes commands on sdMOSI, answers on sdMISO, maps blocks onto a byte memory.
// Response bytes lag the command by one fill byte; the initiator paces everything via sdSCLK, so nothing stalls here.
module sd_spi_responder #(
  parameter int BLK_BITS   = 12,
  parameter int INIT_POLLS = 3,
  parameter int READ_WAIT  = 4,
  parameter int BUSY_BYTES = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sdSCLK,
  input  logic                sdMOSI,
  input  logic                sdCS,
  output logic                sdMISO,
  output logic [BLK_BITS+8:0] mem_addr,
  input  logic [7:0]          mem_rdata,
  output logic [7:0]          mem_wdata,
  output logic                mem_we,
  output logic                card_idle
);

  typedef enum logic [3:0] {
    CMD_WAIT, CMD_RX, RESP, RD_WAIT, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_BUSY
  } state_t;

  state_t              state_q, state_d, post_q, post_d;
  logic [2:0]          sclk_q;
  logic [1:0]          mosi_q, cs_q;
  logic [2:0]          bit_q, bit_d;
  logic [6:0]          rx_q, rx_d;
  logic [7:0]          tx_q, tx_d, next_q, next_d;
  logic                load_q, load_d, from_mem_q, from_mem_d, miso_q, miso_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [5:0]          cmd_q, cmd_d;
  logic [BLK_BITS-1:0] arg_q, arg_d;
  logic [39:0]         resp_q, resp_d;
  logic [2:0]          left_q, left_d;
  logic [8:0]          idx_q, idx_d;
  logic [7:0]          polls_q, polls_d;
  logic                app_q, app_d, idle_q, idle_d, we_q, we_d;
  logic [BLK_BITS+8:0] addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                rise, fall;
  logic [7:0]          rx_byte, tx_byte, r1;
  logic [31:0]         trail;

  assign rise    = sclk_q[1] & ~sclk_q[2];
  assign fall    = ~sclk_q[1] & sclk_q[2];
  assign rx_byte = {rx_q, mosi_q[1]};
  // Data bytes come straight off the memory port; the address was issued at the preceding rising-edge byte boundary.
  assign tx_byte = from_mem_q ? mem_rdata : next_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= 3'b000; mosi_q <= 2'b00; cs_q <= 2'b11;
      state_q <= CMD_WAIT; post_q <= CMD_WAIT; bit_q <= 3'd0; rx_q <= 7'd0;
      tx_q <= 8'hFF; next_q <= 8'hFF; load_q <= 1'b0; from_mem_q <= 1'b0; miso_q <= 1'b1;
      cnt_q <= 8'd0; cmd_q <= 6'd0; arg_q <= '0; resp_q <= 40'd0; left_q <= 3'd0;
      idx_q <= 9'd0; polls_q <= 8'd0; app_q <= 1'b0; idle_q <= 1'b1; we_q <= 1'b0;
      addr_q <= '0; wdata_q <= 8'd0;
    end else begin
      sclk_q <= {sclk_q[1:0], sdSCLK}; mosi_q <= {mosi_q[0], sdMOSI}; cs_q <= {cs_q[0], sdCS};
      state_q <= state_d; post_q <= post_d; bit_q <= bit_d; rx_q <= rx_d;
      tx_q <= tx_d; next_q <= next_d; load_q <= load_d; from_mem_q <= from_mem_d; miso_q <= miso_d;
      cnt_q <= cnt_d; cmd_q <= cmd_d; arg_q <= arg_d; resp_q <= resp_d; left_q <= left_d;
      idx_q <= idx_d; polls_q <= polls_d; app_q <= app_d; idle_q <= idle_d; we_q <= we_d;
      addr_q <= addr_d; wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q; post_d = post_q; bit_d = bit_q; rx_d = rx_q;
    tx_d = tx_q; next_d = next_q; load_d = load_q; from_mem_d = from_mem_q; miso_d = miso_q;
    cnt_d = cnt_q; cmd_d = cmd_q; arg_d = arg_q; resp_d = resp_q; left_d = left_q;
    idx_d = idx_q; polls_d = polls_q; app_d = app_q; idle_d = idle_q; we_d = 1'b0;
    addr_d = addr_q; wdata_d = wdata_q; r1 = 8'h00; trail = 32'h0;
    if (cs_q[1]) begin
      bit_d = 3'd0; state_d = CMD_WAIT; load_d = 1'b0; from_mem_d = 1'b0; tx_d = 8'hFF; miso_d = 1'b1;
    end else begin
      if (fall) begin
        if (load_q) begin
          miso_d = tx_byte[7]; tx_d = {tx_byte[6:0], 1'b1}; load_d = 1'b0;
        end else begin
          miso_d = tx_q[7]; tx_d = {tx_q[6:0], 1'b1};
        end
      end
      if (rise) begin
        rx_d  = rx_byte[6:0];
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          load_d = 1'b1; next_d = 8'hFF; from_mem_d = 1'b0;
          case (state_q)
            CMD_WAIT: if (rx_byte[7:6] == 2'b01) begin
              cmd_d = rx_byte[5:0]; cnt_d = 8'd1; state_d = CMD_RX;
            end
            CMD_RX: begin
              cnt_d = cnt_q + 8'd1;
              // Only the low BLK_BITS of the argument matter (BLK_BITS >= 9 assumed).
              if (cnt_q != 8'd5) arg_d = {arg_q[BLK_BITS-9:0], rx_byte};
              else begin
                r1 = {5'b0, 1'b1, 1'b0, idle_q};
                left_d = 3'd1; post_d = CMD_WAIT; app_d = 1'b0; state_d = RESP;
                case (cmd_q)
                  6'd0:  begin r1 = 8'h01; idle_d = 1'b1; polls_d = 8'd0; end
                  6'd8:  begin r1 = 8'h01; trail = {24'h000001, arg_q[7:0]}; left_d = 3'd5; end
                  6'd16: r1 = {7'b0, idle_q};
                  6'd17: if (!idle_q) begin r1 = 8'h00; post_d = RD_WAIT; end
                  6'd24: if (!idle_q) begin r1 = 8'h00; post_d = WR_TOKEN; end
                  6'd41: if (app_q) begin
                    if (polls_q < 8'(INIT_POLLS)) begin r1 = 8'h01; polls_d = polls_q + 8'd1; end
                    else begin r1 = 8'h00; idle_d = 1'b0; end
                  end
                  6'd55: begin r1 = {7'b0, idle_q}; app_d = 1'b1; end
                  6'd58: begin r1 = {7'b0, idle_q}; trail = 32'hC0FF8000; left_d = 3'd5; end
                  default: ;
                endcase
                resp_d = {r1, trail};
              end
            end
            RESP: begin
              next_d = resp_q[39:32]; resp_d = {resp_q[31:0], 8'h00}; left_d = left_q - 3'd1;
              if (left_q == 3'd1) begin state_d = post_q; cnt_d = 8'd0; end
            end
            RD_WAIT: if (cnt_q < 8'(READ_WAIT)) cnt_d = cnt_q + 8'd1;
                     else begin next_d = 8'hFE; idx_d = 9'd0; state_d = RD_DATA; end
            RD_DATA: begin
              addr_d = {arg_q, idx_q}; from_mem_d = 1'b1; idx_d = idx_q + 9'd1;
              if (idx_q == 9'd511) begin state_d = RD_CRC; cnt_d = 8'd0; end
            end
            RD_CRC: begin
              next_d = 8'h00; cnt_d = cnt_q + 8'd1;
              if (cnt_q == 8'd1) state_d = CMD_WAIT;
            end
            WR_TOKEN: if (rx_byte == 8'hFE) begin idx_d = 9'd0; state_d = WR_DATA; end
            WR_DATA: begin
              addr_d = {arg_q, idx_q}; wdata_d = rx_byte; we_d = 1'b1; idx_d = idx_q + 9'd1;
              if (idx_q == 9'd511) begin state_d = WR_CRC; cnt_d = 8'd0; end
            end
            WR_CRC: begin
              cnt_d = cnt_q + 8'd1;
              if (cnt_q == 8'd1) begin next_d = 8'h05; cnt_d = 8'd0; state_d = WR_BUSY; end
            end
            WR_BUSY: if (cnt_q < 8'(BUSY_BYTES)) begin next_d = 8'h00; cnt_d = cnt_q + 8'd1; end
                     else state_d = CMD_WAIT;
            default: state_d = CMD_WAIT;
          endcase
        end
      end
    end
  end

  assign sdMISO    = miso_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign card_idle = idle_q;

endmodule
